// File: rtl/oddr_gearbox_pkg.sv
// Shared helpers for the DDR output gearbox: beat/phase sizing, ratio legality, lane commands.
package oddr_gearbox_pkg;

    typedef enum logic [1:0] {
        LANE_SHIFT = 2'd0,
        LANE_LOAD  = 2'd1,
        LANE_IDLE  = 2'd2
    } lane_op_e;

    function automatic int unsigned beats_of(input int unsigned ratio);
        return ratio / 2;
    endfunction

    function automatic int unsigned phase_width(input int unsigned ratio);
        return (ratio / 2 > 1) ? $clog2(ratio / 2) : 1;
    endfunction

    function automatic bit ratio_ok(input int unsigned ratio);
        return (ratio % 2 == 0) && (ratio >= 2) && (ratio <= 16);
    endfunction

endpackage

// File: rtl/oddr_gearbox_lane.sv
// One serial lane: RATIO-bit shift register emitting two bits per ECLK toward the DDR cell.
module oddr_gearbox_lane
    import oddr_gearbox_pkg::*;
#(
    parameter int unsigned RATIO      = 4,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter logic        IDLE_VALUE = 1'b0
) (
    input  logic             ECLK,
    input  logic             RSTN,
    input  lane_op_e         op,
    input  logic [RATIO-1:0] word,
    output logic             q_rise,
    output logic             q_fall
);

    logic [RATIO-1:0] sr_q;
    logic [RATIO-1:0] load_word;
    logic [RATIO-1:0] shift_word;

    // Bit order is resolved at load time so the outgoing pair always sits in sr_q[1:0].
    always_comb begin
        load_word  = '0;
        shift_word = {RATIO{IDLE_VALUE}};
        for (int unsigned i = 0; i < RATIO; i++) begin
            load_word[i] = LSB_FIRST ? word[i] : word[RATIO-1-i];
        end
        for (int unsigned i = 0; i + 2 < RATIO; i++) begin
            shift_word[i] = sr_q[i+2];
        end
    end

    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            sr_q <= {RATIO{IDLE_VALUE}};
        end else begin
            case (op)
                LANE_LOAD: sr_q <= load_word;
                LANE_IDLE: sr_q <= {RATIO{IDLE_VALUE}};
                default:   sr_q <= shift_word;
            endcase
        end
    end

    assign q_rise = sr_q[0];
    assign q_fall = sr_q[1];

endmodule

// File: rtl/oddr_gearbox.sv
// Multi-channel output gearbox: parallel words in over valid/ready, rise/fall bit pairs out per ECLK.
module oddr_gearbox
    import oddr_gearbox_pkg::*;
#(
    parameter  int unsigned CHANNELS   = 4,
    parameter  int unsigned RATIO      = 4,
    parameter  bit          LSB_FIRST  = 1'b1,
    parameter  logic        IDLE_VALUE = 1'b0,
    localparam int unsigned PW         = phase_width(RATIO)
) (
    input  logic                      ECLK,
    input  logic                      RSTN,
    input  logic [CHANNELS*RATIO-1:0] S_DATA,
    input  logic                      S_VALID,
    output logic                      S_READY,
    input  logic                      SYNC,
    output logic [CHANNELS-1:0]       Q_RISE,
    output logic [CHANNELS-1:0]       Q_FALL,
    output logic [PW-1:0]             PHASE,
    output logic                      UNDERFLOW,
    output logic [15:0]               UNDERFLOW_CNT
);

    localparam int unsigned   BEATS      = beats_of(RATIO);
    localparam logic [PW-1:0] LAST_PHASE = PW'(BEATS - 1);

    if (!ratio_ok(RATIO)) begin : g_bad_ratio
        $error("oddr_gearbox: RATIO must be even and within 2..16");
    end

    logic [PW-1:0]             phase_q;
    logic                      hold_full_q;
    logic [CHANNELS*RATIO-1:0] hold_q;
    logic                      primed_q;
    logic                      uf_q;
    logic [15:0]               uf_cnt_q;
    logic                      boundary;
    logic                      accept;
    logic                      starved;
    lane_op_e                  lane_op;

    assign boundary = (phase_q == LAST_PHASE) || SYNC;
    assign S_READY  = RSTN && (!hold_full_q || boundary);
    assign accept   = S_VALID && S_READY;
    assign starved  = boundary && !hold_full_q;

    always_comb begin
        lane_op = LANE_SHIFT;
        if (boundary) begin
            lane_op = hold_full_q ? LANE_LOAD : LANE_IDLE;
        end
    end

    // Lanes sample the old hold_q on a boundary, so a same-edge accept safely overwrites it.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            phase_q     <= LAST_PHASE;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            primed_q    <= 1'b0;
            uf_q        <= 1'b0;
            uf_cnt_q    <= '0;
        end else begin
            phase_q  <= boundary ? '0 : phase_q + 1'b1;
            primed_q <= primed_q | accept;
            uf_q     <= starved && primed_q;
            if (starved && primed_q && (uf_cnt_q != '1)) begin
                uf_cnt_q <= uf_cnt_q + 16'd1;
            end
            if (accept) begin
                hold_q      <= S_DATA;
                hold_full_q <= 1'b1;
            end else if (boundary) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        oddr_gearbox_lane #(
            .RATIO      (RATIO),
            .LSB_FIRST  (LSB_FIRST),
            .IDLE_VALUE (IDLE_VALUE)
        ) u_lane (
            .ECLK   (ECLK),
            .RSTN   (RSTN),
            .op     (lane_op),
            .word   (hold_q[c*RATIO +: RATIO]),
            .q_rise (Q_RISE[c]),
            .q_fall (Q_FALL[c])
        );
    end

    assign PHASE         = phase_q;
    assign UNDERFLOW     = uf_q;
    assign UNDERFLOW_CNT = uf_cnt_q;

endmodule

// File: doc/oddr_gearbox.md
Name: oddr_gearbox

Overview:
- Parametrised, multi-channel output gearbox: accepts RATIO-bit parallel words per channel over a valid/ready handshake and emits one rise/fall bit pair per channel per ECLK cycle, for a downstream DDR output cell.
- Generalises the fixed 4:1 DDR output serializer: configurable ratio, channel count, bit order and idle pattern.
- Adds a skid holding register, underflow detection and counting, and synchronous phase realignment.
- Sits between the parallel video/memory datapath and the pad-side DDR output cells.

Parameters:
- CHANNELS, 4, number of independent serial lanes sharing one phase counter.
- RATIO, 4, bits per channel per word; even, 2..16.
- LSB_FIRST, 1, 1 = bit 0 leaves first; 0 = bit RATIO-1 leaves first.
- IDLE_VALUE, 1'b0, bit driven on every Q when no data is loaded.

Ports:
- ECLK  in  1  single clock; all logic rising-edge.
- RSTN  in  1  asynchronous, active-low reset.
- S_DATA  in  CHANNELS*RATIO  channel c = S_DATA[c*RATIO +: RATIO].
- S_VALID  in  1  word offered.
- S_READY  out  1  word accepted on an edge where S_VALID && S_READY.
- SYNC  in  1  one-cycle pulse; forces a word boundary on the next edge.
- Q_RISE  out  CHANNELS  bit for the rising half of the DDR cell.
- Q_FALL  out  CHANNELS  bit for the falling half.
- PHASE  out  PW  current beat, 0..BEATS-1; PW = max(1, clog2(BEATS)).
- UNDERFLOW  out  1  one-cycle pulse on a starved boundary.
- UNDERFLOW_CNT  out  16  saturating underflow count.

Behaviour:
- BEATS = RATIO/2. A boundary edge is an edge where PHASE == BEATS-1 or SYNC == 1.
- Reset (RSTN low, async):
  - PHASE = BEATS-1, so the first edge after release is a boundary.
  - Shift registers = all IDLE_VALUE; Q_RISE/Q_FALL = all IDLE_VALUE.
  - Hold empty, primed = 0, UNDERFLOW = 0, UNDERFLOW_CNT = 0.
  - S_READY is 0 while RSTN is low.
  - Reset mid-word discards hold and shift contents and does not count an underflow.
- Phase counter: on a boundary edge PHASE <= 0; otherwise PHASE <= PHASE+1. For RATIO=2, every edge is a boundary.
- SYNC:
  - Discards the partially shifted word.
  - Loads the shift register exactly as a normal boundary does.
  - The new word starts at PHASE 0.
- Holding register: one word deep, shared by all channels.
  - S_READY = RSTN && (!hold_full || boundary_now); combinational from hold_full, PHASE and SYNC.
- Boundary edge, hold full: shift register <= hold; hold empties unless a new word is accepted on the same edge. On simultaneous accept and load, hold takes the new word and the shift register takes the old one.
- Boundary edge, hold empty:
  - Shift register <= all IDLE_VALUE.
  - If primed, UNDERFLOW = 1 for the following cycle and UNDERFLOW_CNT increments, saturating at 16'hFFFF.
- primed sets on the first accepted word; only reset clears it.
- Non-boundary edge: each lane shifts by two bits toward the output end and fills with IDLE_VALUE.
- Output mapping (while PHASE == k, Q shows the word loaded at the previous boundary):
  - LSB_FIRST=1: Q_RISE[c] = bit 2k, Q_FALL[c] = bit 2k+1.
  - LSB_FIRST=0: Q_RISE[c] = bit RATIO-1-2k, Q_FALL[c] = bit RATIO-2-2k.
  - Q is driven directly from lane flops; there is no combinational path from S_DATA.
- Latency: a word accepted at an edge while hold is empty and not at a boundary appears on Q in the cycle after the next boundary edge.
- Throughput: one word per BEATS cycles, sustained with no bubbles when S_VALID is held high.

Decomposition:
- Package oddr_gearbox_pkg: BEATS and PW calculation functions; a RATIO legality check (even, 2..16) raising an elaboration error.
- Sub-module oddr_gearbox_lane: one channel's RATIO-bit shift register with load/shift/idle fill and bit-order mapping; instantiated CHANNELS times.
- Top level owns the phase counter, holding register, handshake, primed flag and underflow logic.

Test Plan:
- Reset release, S_VALID=0: Q = IDLE_VALUE on every lane, S_READY=1, PHASE cycles 1,0,1,0 (RATIO=4), no UNDERFLOW.
- RATIO=4, LSB_FIRST=1, ch0 word 4'b1101 streamed back-to-back: ch0 (rise,fall) = (1,0) then (1,1) per word, repeating; no gaps; UNDERFLOW_CNT stays 0.
- LSB_FIRST=0, RATIO=8, ch2 = 8'hA5: ch2 (rise,fall) pairs are (1,0),(1,0),(0,1),(0,1).
- Stop S_VALID after 3 words: exactly one UNDERFLOW pulse per subsequent boundary; UNDERFLOW_CNT counts 1,2,3…; Q returns to IDLE_VALUE; force the counter to 16'hFFFE and confirm it saturates at 16'hFFFF.
- SYNC pulse at PHASE=1 (RATIO=8): PHASE goes to 0 on the next cycle; the held word appears starting at bits 0/1; the remainder of the old word is never output.
- RSTN low mid-word with hold full: Q immediately goes to IDLE_VALUE, S_READY=0; after release no UNDERFLOW until a new word has been accepted.
